// File: rtl/pcs_sync_pkg.sv
// rtl/pcs_sync_pkg.sv - shared state encoding and comma/K28.5 constants for the PCS sync block
package pcs_sync_pkg;

    typedef enum logic [1:0] {
        LOSS_OF_SYNC,
        COMMA_DETECT,
        ACQUIRE_SYNC,
        SYNC_ACQUIRED
    } sync_state_t;

    localparam logic [6:0] COMMA_MINUS = 7'b0011111;
    localparam logic [6:0] COMMA_PLUS  = 7'b1100000;

    localparam logic [9:0] K28_5_RDN = 10'b0011111010;
    localparam logic [9:0] K28_5_RDP = 10'b1100000101;

    function automatic logic is_comma(input logic [6:0] cg_hi);
        return (cg_hi == COMMA_MINUS) || (cg_hi == COMMA_PLUS);
    endfunction

endpackage

// File: rtl/pcs_comma_detect.sv
// rtl/pcs_comma_detect.sv - combinational comma, bad-code-group and data qualifiers
module pcs_comma_detect
    import pcs_sync_pkg::*;
(
    input  logic [6:0] cg_hi,
    input  logic       cg_valid,
    input  logic       cg_ctrl,
    input  logic       rxeven,
    output logic       comma,
    output logic       cgbad,
    output logic       cgd
);

    // A comma is only legitimate in the even slot; seen in the odd slot it is an error.
    assign comma = is_comma(cg_hi);
    assign cgbad = ~cg_valid | (comma & rxeven);
    assign cgd   = cg_valid & ~cg_ctrl;

endmodule

// File: rtl/pcs_sync_gen.sv
// rtl/pcs_sync_gen.sv - 1000BASE-X receive code-group synchronization; SYNC_LOSS_CNT_EN adds sync_loss_cnt
module pcs_sync_gen
    import pcs_sync_pkg::*;
#(
    parameter int CG_W         = 10,
    parameter int ACQ_COMMAS   = 3,
    parameter int LOSS_BAD     = 4,
    parameter int RECOVER_GOOD = 4,
    parameter int LOSS_CNT_W   = 8
) (
    input  logic            GTX_CLK,
    input  logic            mr_main_reset,
    input  logic [CG_W-1:0] rx_code_groupIN,
    input  logic            rx_cg_valid,
    input  logic            rx_cg_ctrl,
    output logic [CG_W-1:0] SUDI,
    output logic            sync_status,
    output logic            rxeven
`ifdef SYNC_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] sync_loss_cnt
`endif
);

    localparam int CC_W = $clog2(ACQ_COMMAS + 1);
    localparam int BC_W = $clog2(LOSS_BAD + 1);
    localparam int GC_W = $clog2(RECOVER_GOOD + 1);

    localparam logic [CC_W-1:0] COMMA_ONE  = CC_W'(1);
    localparam logic [CC_W-1:0] COMMA_LAST = CC_W'(ACQ_COMMAS - 1);
    localparam logic [CC_W-1:0] COMMA_FULL = CC_W'(ACQ_COMMAS);
    localparam logic [BC_W-1:0] BAD_ONE    = BC_W'(1);
    localparam logic [BC_W-1:0] BAD_LAST   = BC_W'(LOSS_BAD - 1);
    localparam logic [GC_W-1:0] GOOD_ONE   = GC_W'(1);
    localparam logic [GC_W-1:0] GOOD_LAST  = GC_W'(RECOVER_GOOD - 1);

    sync_state_t     state;
    logic [CC_W-1:0] comma_cnt;
    logic [BC_W-1:0] bad_cnt;
    logic [GC_W-1:0] good_cnt;
    logic            comma;
    logic            cgbad;
    logic            cgd;

    pcs_comma_detect u_comma_detect (
        .cg_hi    (rx_code_groupIN[CG_W-1 -: 7]),
        .cg_valid (rx_cg_valid),
        .cg_ctrl  (rx_cg_ctrl),
        .rxeven   (rxeven),
        .comma    (comma),
        .cgbad    (cgbad),
        .cgd      (cgd)
    );

    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            state       <= LOSS_OF_SYNC;
            sync_status <= 1'b0;
            rxeven      <= 1'b0;
            SUDI        <= '0;
            comma_cnt   <= '0;
            bad_cnt     <= '0;
            good_cnt    <= '0;
        end else begin
            SUDI   <= rx_code_groupIN;
            rxeven <= ~rxeven;
            case (state)
                LOSS_OF_SYNC: begin
                    if (comma) begin
                        state     <= COMMA_DETECT;
                        rxeven    <= 1'b1;
                        comma_cnt <= COMMA_ONE;
                    end
                end
                COMMA_DETECT: begin
                    if (cgd) begin
                        rxeven <= 1'b0;
                        // Only reachable with a single-comma acquisition
                        if (comma_cnt == COMMA_FULL) begin
                            state       <= SYNC_ACQUIRED;
                            sync_status <= 1'b1;
                            bad_cnt     <= '0;
                            good_cnt    <= '0;
                        end else begin
                            state <= ACQUIRE_SYNC;
                        end
                    end else begin
                        state     <= LOSS_OF_SYNC;
                        comma_cnt <= '0;
                    end
                end
                ACQUIRE_SYNC: begin
                    if (cgbad) begin
                        state     <= LOSS_OF_SYNC;
                        comma_cnt <= '0;
                    end else if (comma && !rxeven) begin
                        rxeven <= 1'b1;
                        if (comma_cnt == COMMA_LAST) begin
                            state       <= SYNC_ACQUIRED;
                            sync_status <= 1'b1;
                            comma_cnt   <= COMMA_FULL;
                            bad_cnt     <= '0;
                            good_cnt    <= '0;
                        end else begin
                            state     <= COMMA_DETECT;
                            comma_cnt <= comma_cnt + COMMA_ONE;
                        end
                    end
                end
                SYNC_ACQUIRED: begin
                    if (cgbad) begin
                        good_cnt <= '0;
                        if (bad_cnt == BAD_LAST) begin
                            state       <= LOSS_OF_SYNC;
                            sync_status <= 1'b0;
                            comma_cnt   <= '0;
                            bad_cnt     <= '0;
                        end else begin
                            bad_cnt <= bad_cnt + BAD_ONE;
                        end
                    end else if (bad_cnt != '0) begin
                        // A run of good code-groups forgives one earlier error
                        if (good_cnt == GOOD_LAST) begin
                            bad_cnt  <= bad_cnt - BAD_ONE;
                            good_cnt <= '0;
                        end else begin
                            good_cnt <= good_cnt + GOOD_ONE;
                        end
                    end else begin
                        good_cnt <= '0;
                    end
                end
                default: state <= LOSS_OF_SYNC;
            endcase
        end
    end

`ifdef SYNC_LOSS_CNT_EN
    always_ff @(posedge GTX_CLK) begin
        if (mr_main_reset) begin
            sync_loss_cnt <= '0;
        end else if (state == SYNC_ACQUIRED && cgbad && bad_cnt == BAD_LAST
                     && sync_loss_cnt != '1) begin
            sync_loss_cnt <= sync_loss_cnt + LOSS_CNT_W'(1);
        end
    end
`endif

endmodule
